// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions for the 16-bit CPU front end:
// sequencing FSM states and fixed encodings used by the hazard controller.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MUL_WAIT = 2'd2
    } pc_state_e;

    localparam logic [15:0] NOP_INSTR = 16'h0000;
    localparam int unsigned REG_ZERO  = 0;

endpackage

// File: rtl/pc_hazard_ctrl_sat_counter.sv
// Saturating up-counter with clear. clr together with inc restarts the
// count at 1, so a fresh run can begin in the same cycle the old one ends.
module sat_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear/restart, else saturating increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? WIDTH'(1) : '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register, asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pc_hazard_ctrl.sv
// Pipeline sequencing controller: decides PC/IF-ID advance, hold or flush
// and ID/EX bubble injection for load-use, taken-branch and multi-cycle
// multiply hazards. Optional macro HAZARD_PERF_CNT_EN adds stall_total and
// flush_total performance counters.
module pc_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned REG_W        = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MUL_TIMEOUT  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             branch_taken,
    input  logic             mul_start,
    input  logic             mul_done,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [2:0]       consec_stall,
    output logic             mul_err,
    output logic [1:0]       state_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]      stall_total,
    output logic [15:0]      flush_total
`endif
);

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] MUL_LIMIT    = 8'(MUL_TIMEOUT);

    pc_state_e  state_q, state_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic       mul_err_q, mul_err_d;
    logic [7:0] mul_cnt;
    logic       mul_cnt_clr, mul_cnt_inc;
    logic       branch_event;
    logic       load_use;

    assign load_use = ex_mem_read && (ex_rd != REG_W'(REG_ZERO)) &&
                      ((ex_rd == id_rs) || (ex_rd == id_rt));

    // Next-state and hazard outputs; everything forced low while reset is held.
    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        mul_err_d    = mul_err_q;
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        branch_event = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    ifid_flush   = 1'b1;
                    idex_bubble  = 1'b1;
                    branch_event = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_RELOAD;
                    end
                end else if (mul_start) begin
                    pc_hold   = 1'b1;
                    ifid_hold = 1'b1;
                    if (!mul_done) begin
                        state_d = ST_MUL_WAIT;
                    end
                end else if (load_use) begin
                    pc_hold     = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                end
            end
            ST_FLUSH: begin
                ifid_flush = 1'b1;
                if (branch_taken) begin
                    branch_event = 1'b1;
                    flush_cnt_d  = FLUSH_RELOAD;
                end else if (flush_cnt_q <= 3'd1) begin
                    flush_cnt_d = '0;
                    state_d     = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            ST_MUL_WAIT: begin
                if (mul_done) begin
                    state_d = ST_RUN;
                end else begin
                    pc_hold     = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                    if (mul_cnt == MUL_LIMIT) begin
                        mul_err_d = 1'b1;
                        state_d   = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (!reset) begin
            pc_hold      = 1'b0;
            ifid_hold    = 1'b0;
            ifid_flush   = 1'b0;
            idex_bubble  = 1'b0;
            branch_event = 1'b0;
        end
    end

    // State, flush countdown and sticky error registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            mul_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            mul_err_q   <= mul_err_d;
        end
    end

    // mul_cnt restarts at 1 on entry to MUL_WAIT and counts each further wait cycle.
    assign mul_cnt_inc = (state_d == ST_MUL_WAIT);
    assign mul_cnt_clr = (state_q != ST_MUL_WAIT) || (state_d != ST_MUL_WAIT);

    sat_counter #(.WIDTH(8)) u_mul_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (mul_cnt_clr),
        .inc   (mul_cnt_inc),
        .count (mul_cnt)
    );

    sat_counter #(.WIDTH(3)) u_consec_stall (
        .clk   (clk),
        .reset (reset),
        .clr   (!pc_hold),
        .inc   (pc_hold),
        .count (consec_stall)
    );

`ifdef HAZARD_PERF_CNT_EN
    sat_counter #(.WIDTH(16)) u_stall_total (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (pc_hold),
        .count (stall_total)
    );

    sat_counter #(.WIDTH(16)) u_flush_total (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (branch_event),
        .count (flush_total)
    );
`endif

    assign mul_err = mul_err_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_pc_hazard_ctrl.sv
// Scoreboard bench for pc_hazard_ctrl: a driver applies stimulus after each
// posedge and pushes the reference model's expected outputs; a monitor pops
// and compares on each negedge.
module tb_pc_hazard_ctrl;

    localparam int REG_W        = 4;
    localparam int FLUSH_CYCLES = 2;
    localparam int MUL_TIMEOUT  = 32;

    typedef struct packed {
        logic       ph;
        logic       ih;
        logic       fl;
        logic       bub;
        logic [2:0] cs;
        logic       err;
        logic [1:0] st;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [REG_W-1:0] id_rs = '0;
    logic [REG_W-1:0] id_rt = '0;
    logic             ex_mem_read = 1'b0;
    logic [REG_W-1:0] ex_rd = '0;
    logic             branch_taken = 1'b0;
    logic             mul_start = 1'b0;
    logic             mul_done = 1'b0;
    logic             pc_hold, ifid_hold, ifid_flush, idex_bubble, mul_err;
    logic [2:0]       consec_stall;
    logic [1:0]       state_o;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t q[$];

    // Reference model state, kept as remaining-work counts rather than FSM states.
    int   m_flush_left = 0;
    bit   m_mul        = 0;
    int   m_waited     = 0;
    int   m_consec     = 0;
    bit   m_err        = 0;

    pc_hazard_ctrl #(
        .REG_W        (REG_W),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .MUL_TIMEOUT  (MUL_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .branch_taken (branch_taken),
        .mul_start    (mul_start),
        .mul_done     (mul_done),
        .pc_hold      (pc_hold),
        .ifid_hold    (ifid_hold),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .consec_stall (consec_stall),
        .mul_err      (mul_err),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    task automatic cycle(input logic rst, input logic [3:0] rs, input logic [3:0] rt,
                         input logic mr, input logic [3:0] rd,
                         input logic br, input logic ms, input logic md);
        exp_t e;
        bit   lu;
        @(posedge clk);
        #1;
        reset = rst; id_rs = rs; id_rt = rt; ex_mem_read = mr; ex_rd = rd;
        branch_taken = br; mul_start = ms; mul_done = md;
        cyc++;
        e = '0;
        if (!rst) begin
            m_flush_left = 0; m_mul = 0; m_waited = 0; m_consec = 0; m_err = 0;
            q.push_back(e);
            return;
        end
        e.cs  = 3'(m_consec);
        e.err = m_err;
        e.st  = (m_flush_left > 0) ? 2'd1 : (m_mul ? 2'd2 : 2'd0);
        lu = mr && (rd != 0) && ((rd == rs) || (rd == rt));
        if (m_flush_left > 0) begin
            e.fl = 1'b1;
            if (br) m_flush_left = FLUSH_CYCLES - 1;
            else    m_flush_left--;
        end else if (m_mul) begin
            if (md) begin
                m_mul = 0;
            end else begin
                e.ph = 1'b1; e.ih = 1'b1; e.bub = 1'b1;
                m_waited++;
                if (m_waited == MUL_TIMEOUT) begin
                    m_err = 1;
                    m_mul = 0;
                end
            end
        end else if (br) begin
            e.fl = 1'b1; e.bub = 1'b1;
            m_flush_left = FLUSH_CYCLES - 1;
        end else if (ms) begin
            e.ph = 1'b1; e.ih = 1'b1;
            if (!md) begin
                m_mul = 1; m_waited = 0;
            end
        end else if (lu) begin
            e.ph = 1'b1; e.ih = 1'b1; e.bub = 1'b1;
        end
        q.push_back(e);
        m_consec = e.ph ? ((m_consec >= 7) ? 7 : m_consec + 1) : 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare DUT outputs against the oldest expected entry.
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {pc_hold, ifid_hold, ifid_flush, idex_bubble, consec_stall, mul_err, state_o};
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL outputs cycle %0d: got ph=%b ih=%b fl=%b bub=%b cs=%0d err=%b st=%0d, want ph=%b ih=%b fl=%b bub=%b cs=%0d err=%b st=%0d",
                             cyc, a.ph, a.ih, a.fl, a.bub, a.cs, a.err, a.st,
                             e.ph, e.ih, e.fl, e.bub, e.cs, e.err, e.st);
                end
            end
        end
    end

    // Driver: directed scenarios followed by randomized traffic.
    initial begin
        for (int i = 0; i < 3; i++)
            cycle(0, 4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
        idle(2);
        // load-use on rs, then rt, then rd=0 (no hazard)
        cycle(1, 3, 5, 1, 3, 0, 0, 0); idle(2);
        cycle(1, 6, 7, 1, 7, 0, 0, 0); idle(2);
        cycle(1, 0, 0, 1, 0, 0, 0, 0); idle(2);
        // taken branch, then branch with load-use, then branch during flush
        cycle(1, 0, 0, 0, 0, 1, 0, 0); idle(3);
        cycle(1, 3, 0, 1, 3, 1, 0, 0); idle(3);
        cycle(1, 0, 0, 0, 0, 1, 0, 0); cycle(1, 0, 0, 0, 0, 1, 0, 0); idle(3);
        // multiply done after 5 wait cycles, then a longer one to saturate
        cycle(1, 0, 0, 0, 0, 0, 1, 0); idle(5); cycle(1, 0, 0, 0, 0, 0, 0, 1); idle(2);
        cycle(1, 0, 0, 0, 0, 0, 1, 0); idle(10); cycle(1, 0, 0, 0, 0, 0, 0, 1); idle(2);
        // mul_start with mul_done in the same cycle
        cycle(1, 0, 0, 0, 0, 0, 1, 1); idle(2);
        // timeout, sticky error
        cycle(1, 0, 0, 0, 0, 0, 1, 0); idle(MUL_TIMEOUT + 4);
        cycle(1, 2, 0, 1, 2, 0, 0, 0); idle(2);
        // reset during MUL_WAIT clears everything asynchronously
        cycle(1, 0, 0, 0, 0, 0, 1, 0); idle(2);
        cycle(0, 0, 0, 0, 0, 0, 1, 0); cycle(0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) != 0),
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 5) == 0));
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_hazard_ctrl.md
Name: pc_hazard_ctrl

Overview:
Pipeline sequencing controller for the 16-bit CPU front end. It decides each cycle whether the PC register and IF/ID latch advance, hold, or flush. It also decides when a bubble is injected into ID/EX. It handles three hazard sources: load-use, branch-taken redirect, and multi-cycle multiply. It drives the PC stall input ("repeated") and produces the consecutive-stall count consumed alongside it.

Parameters:
REG_W, 4, register-index width
FLUSH_CYCLES, 2, total cycles of IF/ID flush after taken branch (1..7)
MUL_TIMEOUT, 32, max MUL_WAIT cycles before mul_err (2..255)

Ports:
clk  in  1  clock; state updates on posedge so outputs are stable before the PC's negedge latch
reset  in  1  asynchronous, active-low reset
id_rs  in  REG_W  source reg A of instruction in ID
id_rt  in  REG_W  source reg B of instruction in ID
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  REG_W  destination reg of instruction in EX
branch_taken  in  1  EX resolved a taken branch/jump this cycle
mul_start  in  1  EX issued a multi-cycle multiply this cycle
mul_done  in  1  multiplier result valid (pulse)
pc_hold  out  1  to PC "repeated": keep address
ifid_hold  out  1  IF/ID keeps contents
ifid_flush  out  1  IF/ID loads NOP
idex_bubble  out  1  ID/EX loads NOP
consec_stall  out  3  consecutive pc_hold cycles, saturates at 7
mul_err  out  1  sticky, multiply timed out
state_o  out  2  current FSM state for debug

Behaviour:
- Reset (reset=0, async): state=RUN; flush_cnt=0; mul_cnt=0; consec_stall=0; mul_err=0. All combinational outputs evaluate to 0 in RUN with no hazard.
- load_use = ex_mem_read & (ex_rd != 0) & (ex_rd == id_rs | ex_rd == id_rt). Register 0 never creates a hazard.
- States are RUN=0, FLUSH=1, MUL_WAIT=2. Encoding 3 is illegal and goes to RUN on the next edge.
- Outputs are combinational from state and inputs.
- RUN, branch_taken=1 (highest priority, overrides load_use and mul_start):
  - ifid_flush=1, idex_bubble=1, pc_hold=0.
  - If FLUSH_CYCLES>1: next state FLUSH, flush_cnt=FLUSH_CYCLES-1.
- RUN, else mul_start=1:
  - pc_hold=1, ifid_hold=1, idex_bubble=0.
  - Next state MUL_WAIT, mul_cnt=1.
  - mul_start together with mul_done in the same cycle is treated as a 1-cycle stall and stays in RUN.
- RUN, else load_use=1: pc_hold=1, ifid_hold=1, idex_bubble=1 for exactly this cycle. State stays RUN; the bubble clears the hazard the next cycle.
- FLUSH:
  - ifid_flush=1; pc_hold=0.
  - Decrement flush_cnt; go to RUN when it reaches 1.
  - branch_taken in FLUSH reloads flush_cnt=FLUSH_CYCLES-1.
  - load_use and mul_start are ignored in FLUSH because flushed instructions are NOPs.
- MUL_WAIT:
  - pc_hold=1, ifid_hold=1, idex_bubble=1.
  - mul_done=1 → RUN and release the hold in this same cycle.
  - Otherwise mul_cnt++.
  - If mul_cnt==MUL_TIMEOUT: set mul_err=1 (sticky until reset) and go to RUN.
- consec_stall: on each posedge, if pc_hold=1 then saturating increment (7 max), else 0.
- Reset asserted mid-stall or mid-flush aborts immediately; all outputs return to 0 asynchronously.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs stall_total[15:0] (count of cycles with pc_hold=1) and flush_total[15:0] (taken-branch events).
  - Both saturate at 16'hFFFF.
  - Both clear on reset.
- Undefined: the ports are absent and no counter logic is generated.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state typedef (RUN, FLUSH, MUL_WAIT)
  - NOP_INSTR constant 16'h0000
  - REG_ZERO constant
- One natural sub-module, sat_counter (parameterised width, inc/clr, saturating). It is used for consec_stall, mul_cnt and the perf counters.

Test Plan:
- Reset held low for 3 cycles with random inputs → all outputs 0, state_o=0; release → state RUN.
- ex_mem_read=1, ex_rd=3, id_rs=3 → exactly one cycle of pc_hold=ifid_hold=idex_bubble=1, consec_stall=1 then 0. The same case with ex_rd=0 → no stall.
- branch_taken pulse, FLUSH_CYCLES=2 → ifid_flush=1 for 2 cycles, pc_hold=0. branch_taken together with load_use → flush only, no pc_hold.
- mul_start, mul_done after 5 cycles → pc_hold=1 for 6 cycles, consec_stall saturates at 7 only if the stall is ≥7 cycles, returns to 0 after release.
- mul_start with no mul_done, MUL_TIMEOUT=32 → mul_err=1 at cycle 32, state RUN, mul_err stays 1 until reset.
- Reset asserted during MUL_WAIT (cycle 3) → outputs 0 asynchronously, mul_err=0, state RUN.
